// File: rtl/multiplicador_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_pipe_pkg
//  Purpose  : Shared signed Q-format helpers. Provides the saturation limits
//             and the round-half-up constant for fixed-point arithmetic
//             blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package multiplicador_pipe_pkg;

  // Widest word the helpers can describe. Callers slice the result down to
  // their own width, so any format up to this width is supported.
  localparam int QMAX_W = 64;

  typedef logic [QMAX_W-1:0] qword_t;

  // Largest positive value of a w-bit two's-complement word, 2^(w-1)-1.
  function automatic qword_t q_max(input int w);
    return (qword_t'(1) << (w - 1)) - qword_t'(1);
  endfunction

  // Most negative value of a w-bit two's-complement word, -2^(w-1).
  // Only the low w bits are meaningful.
  function automatic qword_t q_min(input int w);
    return qword_t'(1) << (w - 1);
  endfunction

  // Half an LSB of the kept result when frac bits are discarded. Adding
  // it before truncation rounds half up.
  function automatic qword_t q_round(input int frac);
    return (frac > 0) ? (qword_t'(1) << (frac - 1)) : '0;
  endfunction

endpackage : multiplicador_pipe_pkg
`default_nettype wire

// File: rtl/multiplicador_pipe_sat_round.sv
`default_nettype none
// ============================================================================
//  Module   : sat_round
//  Purpose  : Combinational rounding and saturation of a wide signed value
//             down to a Width-bit Q-format word. Frac LSBs are dropped.
//             An optional half-up rounding step runs before truncation.
//             Out-of-range results clip to the format limits.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_round
  import multiplicador_pipe_pkg::*;
#(
  parameter int InWidth = 32,
  parameter int Width   = 16,
  parameter int Frac    = 12
) (
  input  logic [InWidth-1:0] value_i,
  input  logic               round_en_i,
  output logic [Width-1:0]   y_o,
  output logic               sat_o
);

  // Bits above the kept field, plus the kept sign bit. All of them must
  // agree for the result to be representable.
  localparam int TOP_W = InWidth - Frac - Width + 1;

  localparam qword_t MAX_FULL   = q_max(Width);
  localparam qword_t MIN_FULL   = q_min(Width);
  localparam qword_t ROUND_FULL = q_round(Frac);

  localparam logic [Width-1:0]   MAX_Q   = MAX_FULL[Width-1:0];
  localparam logic [Width-1:0]   MIN_Q   = MIN_FULL[Width-1:0];
  localparam logic [InWidth-1:0] ROUND_K = ROUND_FULL[InWidth-1:0];

  if (TOP_W < 1) begin : g_width_check
    $error("sat_round: InWidth must be at least Frac+Width");
  end

  if (InWidth > QMAX_W) begin : g_qmax_check
    $error("sat_round: InWidth exceeds the Q-format helper range");
  end

  logic [InWidth-1:0] rounded;
  logic [Width-1:0]   cand;
  logic [TOP_W-1:0]   top_bits;
  logic               ovf;

  // Round, select the kept field and clip it when the upper bits show
  // that the value does not fit.
  always_comb begin
    rounded  = value_i + (round_en_i ? ROUND_K : '0);
    cand     = rounded[Frac+Width-1:Frac];
    top_bits = rounded[InWidth-1:Frac+Width-1];
    ovf      = !((&top_bits) || !(|top_bits));
    sat_o    = ovf;
    if (ovf) begin
      y_o = rounded[InWidth-1] ? MIN_Q : MAX_Q;
    end else begin
      y_o = cand;
    end
  end

  // The discarded fraction bits are intentionally dropped.
  if (Frac > 0) begin : g_frac_unused
    logic unused_frac;
    assign unused_frac = ^rounded[Frac-1:0];
  end

endmodule : sat_round
`default_nettype wire

// File: rtl/multiplicador_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_pipe
//  Purpose  : Two-stage pipelined signed Q-format multiplier with
//             valid/ready handshakes, optional half-up rounding, output
//             saturation and a saturated-result counter.
//             S1 holds the full-width product. S2 holds the rounded and
//             saturated result.
//  Revision : 1.0 - initial release
// ============================================================================
module multiplicador_pipe
  import multiplicador_pipe_pkg::*;
#(
  parameter int Width     = 16,
  parameter int Signo     = 1,
  parameter int Magnitud  = 3,
  parameter int Presicion = 12,
  parameter int CntWidth  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Width-1:0]    A,
  input  logic [Width-1:0]    B,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                round_en,
  output logic [Width-1:0]    Y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sat,
  output logic [CntWidth-1:0] sat_count,
  input  logic                cnt_clr
);

  localparam int PROD_W = 2 * Width;

  if (Width != Signo + Magnitud + Presicion) begin : g_format_check
    $error("multiplicador_pipe: Width must equal Signo+Magnitud+Presicion");
  end

  // Pipeline state
  logic                s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0]   prod_q,     prod_d;
  logic                rnd_q,      rnd_d;
  logic                out_valid_q, out_valid_d;
  logic [Width-1:0]    y_q,        y_d;
  logic                sat_q,      sat_d;
  logic [CntWidth-1:0] sat_count_q, sat_count_d;

  // Combinational helpers
  logic                adv;
  logic [PROD_W-1:0]   a_ext;
  logic [PROD_W-1:0]   b_ext;
  logic [Width-1:0]    y_sr;
  logic                sat_sr;

  // The whole pipeline moves when the output slot is empty or being drained.
  // Input acceptance follows directly, so a full pipe keeps streaming.
  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = adv;
  end

  // Stage 1: sign-extend the operands and form the full-width product.
  // The low 2*Width bits of an unsigned product of sign-extended operands
  // equal the two's-complement signed product.
  always_comb begin
    a_ext      = {{Width{A[Width-1]}}, A};
    b_ext      = {{Width{B[Width-1]}}, B};
    s1_valid_d = s1_valid_q;
    prod_d     = prod_q;
    rnd_d      = rnd_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        prod_d = a_ext * b_ext;
        rnd_d  = round_en;
      end
    end
  end

  // Stage 2 arithmetic: round and saturate the stored product.
  sat_round #(
    .InWidth (PROD_W),
    .Width   (Width),
    .Frac    (Presicion)
  ) u_sat_round (
    .value_i    (prod_q),
    .round_en_i (rnd_q),
    .y_o        (y_sr),
    .sat_o      (sat_sr)
  );

  // Stage 2 register: capture the result. Bubbles clear out_valid but leave
  // the data fields untouched.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    sat_d       = sat_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d   = y_sr;
        sat_d = sat_sr;
      end
    end
  end

  // Count delivered saturated results. The count sticks at all-ones, and a
  // clear overrides a simultaneous increment.
  always_comb begin
    sat_count_d = sat_count_q;
    if (cnt_clr) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + CntWidth'(1);
    end
  end

  // State update. Reset empties both stages, so in-flight operands are lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      prod_q      <= '0;
      rnd_q       <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      prod_q      <= prod_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign Y         = y_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;
  assign sat_count = sat_count_q;

endmodule : multiplicador_pipe
`default_nettype wire

// File: tb/tb_multiplicador_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplicador_pipe
//  Purpose  : Self-checking bench for multiplicador_pipe (Q3.12, 16 bits).
//             A queue holds the expected results, and a sat_count model
//             runs alongside the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiplicador_pipe;

  typedef struct packed {
    logic [15:0] y;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        round_en = 1'b0;
  logic [15:0] Y;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sat;
  logic [15:0] sat_count;
  logic        cnt_clr = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  exp_t        sb[$];
  logic [15:0] exp_cnt = '0;

  multiplicador_pipe #(
    .Width     (16),
    .Signo     (1),
    .Magnitud  (3),
    .Presicion (12),
    .CntWidth  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .round_en  (round_en),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat),
    .sat_count (sat_count),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: exact integer product, optional +half LSB, arithmetic
  // shift, then range clip.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic r);
    exp_t   e;
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (r) p = p + 2048;
    p = p >>> 12;
    if (p > 32767) begin
      e.y = 16'h7FFF; e.sat = 1'b1;
    end else if (p < -32768) begin
      e.y = 16'h8000; e.sat = 1'b1;
    end else begin
      e.y = p[15:0]; e.sat = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard and counter model, sampled mid-cycle.
  always @(negedge clk) begin
    logic sat_xfer;
    sat_xfer = 1'b0;
    if (reset) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      check_val("sat_count", {16'h0, sat_count}, {16'h0, exp_cnt});
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_val("unexpected_out_valid", {31'h0, out_valid}, 32'h0);
        end else begin
          check_val("Y", {16'h0, Y}, {16'h0, sb[0].y});
          check_val("sat", {31'h0, sat}, {31'h0, sb[0].sat});
          if (out_ready) begin
            sat_xfer = sb[0].sat;
            void'(sb.pop_front());
            delivered++;
          end
        end
      end
      if (cnt_clr) exp_cnt = '0;
      else if (sat_xfer && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
      if (in_valid && in_ready) sb.push_back(model(A, B, round_en));
    end
  end

  // Present one operand pair and hold it until it is accepted.
  // Call at posedge+#1; the task returns at posedge+#1 of the transfer edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic r);
    int guard;
    guard = 0;
    A = a; B = b; round_en = r; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check_val("drive_timeout", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  // One operation into an idle pipe, with explicit checks on the timing
  // and value of its result.
  task automatic single_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic r, input logic [15:0] ey, input logic es);
    drive(a, b, r);
    in_valid = 1'b0;
    check_val({tag, "_ov_after_s1"}, {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    check_val({tag, "_ov_after_s2"}, {31'h0, out_valid}, 32'h1);
    check_val({tag, "_Y"}, {16'h0, Y}, {16'h0, ey});
    check_val({tag, "_sat"}, {31'h0, sat}, {31'h0, es});
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_val("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check_val("rst_Y", {16'h0, Y}, 32'h0);
    check_val("rst_sat", {31'h0, sat}, 32'h0);
    check_val("rst_sat_count", {16'h0, sat_count}, 32'h0);
    @(posedge clk); #1;

    // Basic product and two-cycle latency: 2.0 * 3.0 = 6.0
    single_op("mul_2x3", 16'h2000, 16'h3000, 1'b0, 16'h6000, 1'b0);
    wait_drain();

    // Saturation in both directions
    single_op("sat_pos", 16'h4000, 16'h4000, 1'b0, 16'h7FFF, 1'b1);
    single_op("sat_neg", 16'hC000, 16'h4000, 1'b0, 16'h8000, 1'b1);
    single_op("sat_minmin", 16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1);
    wait_drain();
    check_val("sat_count_3", {16'h0, sat_count}, 32'h3);

    // Rounding of a half LSB: positive and negative cases
    single_op("trunc_half", 16'h0001, 16'h0800, 1'b0, 16'h0000, 1'b0);
    single_op("round_half", 16'h0001, 16'h0800, 1'b1, 16'h0001, 1'b0);
    single_op("trunc_neg_half", 16'hFFFF, 16'h0800, 1'b0, 16'hFFFF, 1'b0);
    single_op("round_neg_half", 16'hFFFF, 16'h0800, 1'b1, 16'h0000, 1'b0);
    wait_drain();

    // Eight back-to-back operands with a five-cycle output stall mid-stream
    delivered = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check_val("stall_in_ready", {31'h0, in_ready}, 32'h0);
          check_val("stall_out_valid", {31'h0, out_valid}, 32'h1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_val("stream_delivered", delivered, 8);

    // Reset one cycle after a transfer discards the operand
    drive(16'h4000, 16'h4000, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("rst_flush_out_valid", {31'h0, out_valid}, 32'h0);
      @(posedge clk); #1;
    end
    check_val("rst_flush_sat_count", {16'h0, sat_count}, 32'h0);

    // Clear coincident with a saturated output transfer
    drive(16'h4000, 16'h4000, 1'b0);
    drive(16'hC000, 16'h4000, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("clr_pre_count", {16'h0, sat_count}, 32'h1);
    check_val("clr_pre_ov", {31'h0, out_valid & sat}, 32'h1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check_val("clr_count", {16'h0, sat_count}, 32'h0);
    @(posedge clk); #1;
    check_val("clr_count_hold", {16'h0, sat_count}, 32'h0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multiplicador_pipe
`default_nettype wire
